// File: rtl/data_mem.sv
// Y86-64 data memory: quad-word read/write responder on valid/ready channels with ADR range status.
// Optional wait states before each access are compiled in when DMEM_WAIT_EN is defined.
module data_mem #(
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic [3:0]  rsp_stat_o
);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam int         AW       = (MEM_BYTES > 2) ? $clog2(MEM_BYTES) : 1;

  if (MEM_BYTES < 8 || WAIT_CYCLES < 0 || WAIT_CYCLES > 255) begin : g_param_check
    $error("data_mem: MEM_BYTES must be >= 8 and WAIT_CYCLES in 0..255");
  end

  // Channel handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the sender holds valid and its payload stable until that edge.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e      state_q;
  logic        ready_q;
  logic        valid_q;
  logic [63:0] rdata_q;
  logic [3:0]  stat_q;
  logic        write_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
`ifdef DMEM_WAIT_EN
  logic [7:0]  wait_cnt_q;
`endif

  logic [7:0]    mem_q [MEM_BYTES];
  logic [AW-1:0] idx [8];
  logic [63:0]   rd_word;
  logic [64:0]   end_addr;
  logic          adr_err;

  // 65-bit sum so an address near 2^64 cannot wrap back into range.
  assign end_addr = {1'b0, addr_q} + 65'd8;
  assign adr_err  = end_addr > 65'(MEM_BYTES);

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      idx[i] = AW'(addr_q + 64'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = mem_q[idx[i]];
    end
  end

  // Array has no reset; it is only written on the ACCESS edge of an in-range write.
  always_ff @(posedge clk_i) begin
    if (state_q == S_ACCESS && write_q && !adr_err) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[idx[i]] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      rdata_q    <= 64'd0;
      stat_q     <= STAT_AOK;
      write_q    <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
`ifdef DMEM_WAIT_EN
      wait_cnt_q <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (req_valid_i && ready_q) begin
            ready_q <= 1'b0;
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
`ifdef DMEM_WAIT_EN
            if (WAIT_CYCLES > 0) begin
              state_q    <= S_WAIT;
              wait_cnt_q <= 8'(WAIT_CYCLES - 1);
            end else begin
              state_q <= S_ACCESS;
            end
`else
            state_q <= S_ACCESS;
`endif
          end
        end
`ifdef DMEM_WAIT_EN
        S_WAIT: begin
          if (wait_cnt_q == 8'd0) begin
            state_q <= S_ACCESS;
          end else begin
            wait_cnt_q <= wait_cnt_q - 8'd1;
          end
        end
`endif
        S_ACCESS: begin
          valid_q <= 1'b1;
          stat_q  <= adr_err ? STAT_ADR : STAT_AOK;
          rdata_q <= (adr_err || write_q) ? 64'd0 : rd_word;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_stat_o  = stat_q;

endmodule
